detector_jogada: RTL



---
 rtl/detector_jogada.sv | 109 ++++++++++
 1 files changed

// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - switch synchroniser and settle-window play detector
module detector_jogada #(
    parameter int JANELA = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] chaves,
    input  logic       habilita,
    output logic       jogada_pronta,
    output logic [3:0] jogada,
    output logic       jogada_multipla,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        AGUARDA_SOLTA  = 3'd0,
        ARMADO         = 3'd1,
        EST_JANELA     = 3'd2,
        EMITE_VALIDA   = 3'd3,
        EMITE_MULTIPLA = 3'd4
    } estado_t;

    // Counter value on the cycle that takes the last sample of the window.
    localparam logic [3:0] ULTIMA = 4'(JANELA - 1);

    estado_t    estado, estado_prox;
    logic [3:0] sinc_1, chaves_s;
    logic [3:0] captura, captura_prox;
    logic [3:0] contador, contador_prox;
    logic [3:0] jogada_prox;
    logic [3:0] captura_or;

    // Two-stage synchroniser for the asynchronous switches.
    always_ff @(posedge clock) begin
        if (reset) begin
            sinc_1   <= 4'b0000;
            chaves_s <= 4'b0000;
        end else begin
            sinc_1   <= chaves;
            chaves_s <= sinc_1;
        end
    end

    // State, window capture, counter and held play value.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= AGUARDA_SOLTA;
            captura  <= 4'b0000;
            contador <= 4'd0;
            jogada   <= 4'b0000;
        end else begin
            estado   <= estado_prox;
            captura  <= captura_prox;
            contador <= contador_prox;
            jogada   <= jogada_prox;
        end
    end

    assign captura_or = captura | chaves_s;

    // Next-state logic: arm on full release, collect the window, classify.
    always_comb begin
        estado_prox   = estado;
        captura_prox  = captura;
        contador_prox = contador;
        jogada_prox   = jogada;
        case (estado)
            AGUARDA_SOLTA: begin
                // Any key still down (after reset or a play) must be released first.
                if (chaves_s == 4'b0000) begin
                    estado_prox = ARMADO;
                end
            end
            ARMADO: begin
                if (habilita && (chaves_s != 4'b0000)) begin
                    estado_prox   = EST_JANELA;
                    captura_prox  = chaves_s;
                    contador_prox = 4'd1;
                end
            end
            EST_JANELA: begin
                captura_prox  = captura_or;
                contador_prox = contador + 4'd1;
                if (!habilita) begin
                    estado_prox = AGUARDA_SOLTA;
                end else if (chaves_s == 4'b0000) begin
                    // Released before the window closed: treat as bounce.
                    estado_prox = AGUARDA_SOLTA;
                end else if (contador == ULTIMA) begin
                    if ($onehot(captura_or)) begin
                        estado_prox = EMITE_VALIDA;
                        // Loaded on entry so jogada is valid alongside the pulse.
                        jogada_prox = captura_or;
                    end else begin
                        estado_prox = EMITE_MULTIPLA;
                    end
                end
            end
            EMITE_VALIDA:   estado_prox = AGUARDA_SOLTA;
            EMITE_MULTIPLA: estado_prox = AGUARDA_SOLTA;
            default:        estado_prox = AGUARDA_SOLTA;
        endcase
    end

    assign jogada_pronta   = (estado == EMITE_VALIDA);
    assign jogada_multipla = (estado == EMITE_MULTIPLA);
    assign db_estado       = estado;

endmodule
